// File: rtl/velocity_mu_broadcast_scheduler_pkg.sv
// Shared types for the velocity motion-update broadcast scheduler.
package velocity_mu_broadcast_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    DRAIN  = 2'b10,
    GUARD  = 2'b11
  } mu_state_t;

  // A velocity and a destination cell are both packed 3-component vectors.
  localparam int unsigned VEC_COMPONENTS = 3;

  function automatic int unsigned vec_width(input int unsigned comp_width);
    return VEC_COMPONENTS * comp_width;
  endfunction

endpackage

// File: rtl/velocity_mu_broadcast_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr+1 (mod NUM_REQ).
module rr_arbiter
  import velocity_mu_broadcast_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned REQ_ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]      req,
  input  logic [REQ_ID_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]      grant,
  output logic [REQ_ID_WIDTH-1:0] grant_idx,
  output logic                    grant_any
);

  int unsigned        idx;
  logic [NUM_REQ-1:0] rotated;

  // Scan requesters starting just past the last winner; first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    rotated   = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx     = (32'(ptr) + off) % NUM_REQ;
      rotated = req >> idx;
      if (!grant_any && rotated[0]) begin
        grant_any = 1'b1;
        grant     = NUM_REQ'(1) << idx;
        grant_idx = REQ_ID_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/velocity_mu_broadcast_scheduler.sv
// Motion-update pass sequencer and round-robin broadcast bus arbiter.
// Optional per-pass statistics counters are built when MU_SCHED_STATS_EN is defined.
module velocity_mu_broadcast_scheduler
  import velocity_mu_broadcast_scheduler_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned CELL_ID_WIDTH = 4,
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned REQ_ID_WIDTH  = 2,
  parameter int unsigned GUARD_CYCLES  = 3
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          mu_start,
  input  logic [NUM_REQ-1:0]                            req_valid,
  input  logic [NUM_REQ*VEC_COMPONENTS*DATA_WIDTH-1:0]    req_data,
  input  logic [NUM_REQ*VEC_COMPONENTS*CELL_ID_WIDTH-1:0] req_dst_cell,
  input  logic [NUM_REQ-1:0]                            req_last,
  input  logic [NUM_REQ-1:0]                            req_empty_done,
  output logic [NUM_REQ-1:0]                            req_ready,
  output logic                                          motion_update_enable,
  output logic [VEC_COMPONENTS*DATA_WIDTH-1:0]            out_data,
  output logic [VEC_COMPONENTS*CELL_ID_WIDTH-1:0]         out_dst_cell,
  output logic                                          out_valid,
  output logic                                          mu_busy,
`ifdef MU_SCHED_STATS_EN
  output logic [15:0]                                   stat_bcast_count,
  output logic [15:0]                                   stat_stall_count,
`endif
  output logic                                          mu_done
);

  localparam int unsigned VW = vec_width(DATA_WIDTH);
  localparam int unsigned CW = vec_width(CELL_ID_WIDTH);
  localparam int unsigned GW = $clog2(GUARD_CYCLES + 1);

  mu_state_t               state_q, state_d;
  logic [NUM_REQ-1:0]      done_mask_q, done_mask_d;
  logic [REQ_ID_WIDTH-1:0] rr_ptr_q;
  logic [GW-1:0]           guard_cnt_q;
  logic [NUM_REQ-1:0]      arb_req, grant;
  logic [REQ_ID_WIDTH-1:0] grant_idx;
  logic                    xfer;
  logic                    start_accept;
  logic [VW-1:0]           sel_data;
  logic [CW-1:0]           sel_cell;

  // Finished requesters are masked out so they never see ready again.
  assign arb_req      = (state_q == ACTIVE) ? (req_valid & ~done_mask_q) : '0;
  assign req_ready    = grant;
  assign start_accept = (state_q == IDLE) && mu_start;

  rr_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .REQ_ID_WIDTH (REQ_ID_WIDTH)
  ) u_arb (
    .req       (arb_req),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (xfer)
  );

  // One-hot select of the granted requester's slices.
  always_comb begin
    sel_data = '0;
    sel_cell = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_data = sel_data | req_data[i*VW +: VW];
        sel_cell = sel_cell | req_dst_cell[i*CW +: CW];
      end
    end
  end

  // Empty-done and last-transfer both retire a requester in the same cycle.
  always_comb begin
    done_mask_d = done_mask_q;
    if (state_q == ACTIVE) begin
      done_mask_d = done_mask_q | req_empty_done | (grant & req_last);
    end
  end

  // Next-state selection for the pass sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (mu_start) state_d = ACTIVE;
      ACTIVE:  if (&done_mask_d) state_d = DRAIN;
      DRAIN:   state_d = GUARD;
      GUARD:   if (guard_cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Registered outputs, broadcast register, pointer, mask and guard counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      motion_update_enable <= 1'b0;
      mu_busy              <= 1'b0;
      mu_done              <= 1'b0;
      out_valid            <= 1'b0;
      out_data             <= '0;
      out_dst_cell         <= '0;
      rr_ptr_q             <= '0;
      done_mask_q          <= '0;
      guard_cnt_q          <= '0;
    end else begin
      // Enable follows the next state so DRAIN keeps it high for the final beat.
      motion_update_enable <= (state_d == ACTIVE) || (state_d == DRAIN);
      mu_busy              <= (state_d != IDLE);
      mu_done              <= (state_q == GUARD) && (guard_cnt_q == '0);
      out_valid            <= xfer;
      if (xfer) begin
        out_data     <= sel_data;
        out_dst_cell <= sel_cell;
        rr_ptr_q     <= grant_idx;
      end
      done_mask_q <= start_accept ? '0 : done_mask_d;
      if (state_q == DRAIN) begin
        guard_cnt_q <= GW'(GUARD_CYCLES - 1);
      end else if ((state_q == GUARD) && (guard_cnt_q != '0)) begin
        guard_cnt_q <= guard_cnt_q - 1'b1;
      end
    end
  end

`ifdef MU_SCHED_STATS_EN
  logic stall;
  assign stall = (state_q == ACTIVE) && (|(req_valid & ~done_mask_q & ~grant));

  // Per-pass saturating transfer and stall counters; cleared by an accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_bcast_count <= '0;
      stat_stall_count <= '0;
    end else if (start_accept) begin
      stat_bcast_count <= '0;
      stat_stall_count <= '0;
    end else begin
      if (xfer && (stat_bcast_count != '1)) stat_bcast_count <= stat_bcast_count + 16'd1;
      if (stall && (stat_stall_count != '1)) stat_stall_count <= stat_stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_velocity_mu_broadcast_scheduler.sv
// Scoreboard bench for velocity_mu_broadcast_scheduler.
module tb_velocity_mu_broadcast_scheduler;

  localparam int DW  = 32;
  localparam int CW  = 4;
  localparam int NR  = 4;
  localparam int RW  = 2;
  localparam int GC  = 3;
  localparam int VW  = 3 * DW;
  localparam int CCW = 3 * CW;

  logic            clk = 1'b0;
  logic            rst;
  logic            mu_start;
  logic [NR-1:0]   req_valid, req_last, req_empty_done, req_ready;
  logic [NR*VW-1:0]  req_data;
  logic [NR*CCW-1:0] req_dst_cell;
  logic            motion_update_enable, out_valid, mu_busy, mu_done;
  logic [VW-1:0]   out_data;
  logic [CCW-1:0]  out_dst_cell;
`ifdef MU_SCHED_STATS_EN
  logic [15:0]     stat_bcast_count, stat_stall_count;
`endif

  always #5 clk = ~clk;

  velocity_mu_broadcast_scheduler #(
    .DATA_WIDTH    (DW),
    .CELL_ID_WIDTH (CW),
    .NUM_REQ       (NR),
    .REQ_ID_WIDTH  (RW),
    .GUARD_CYCLES  (GC)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .mu_start             (mu_start),
    .req_valid            (req_valid),
    .req_data             (req_data),
    .req_dst_cell         (req_dst_cell),
    .req_last             (req_last),
    .req_empty_done       (req_empty_done),
    .req_ready            (req_ready),
    .motion_update_enable (motion_update_enable),
    .out_data             (out_data),
    .out_dst_cell         (out_dst_cell),
    .out_valid            (out_valid),
    .mu_busy              (mu_busy),
`ifdef MU_SCHED_STATS_EN
    .stat_bcast_count     (stat_bcast_count),
    .stat_stall_count     (stat_stall_count),
`endif
    .mu_done              (mu_done)
  );

  typedef struct packed {
    logic [VW-1:0]  d;
    logic [CCW-1:0] c;
  } beat_t;

  beat_t sb[$];

  int tests = 0;
  int fails = 0;

  // Requester model state
  int          cnt[NR];
  int          sent[NR];
  logic [NR-1:0] hold, en_mask, fin;
  int          m_ptr;
  bit          m_act;

  // Per-pass observations
  int cyc, en_rise, en_fall, done_cyc, done_n, nvalid, first_v, last_v, m_bcast, m_stall, sc;
  bit en_prev;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] pdata(input int i, input int k);
    logic [31:0] b;
    b = 32'hA000_0000 | (32'(i) << 8) | (32'(k) << 4);
    return {b | 32'd3, b | 32'd2, b | 32'd1};
  endfunction

  function automatic logic [CCW-1:0] pcell(input int i, input int k);
    return {4'(i), 4'(k), 4'(i + k + 5)};
  endfunction

  function automatic logic [NR-1:0] exp_grant(input logic [NR-1:0] v, input logic [NR-1:0] f, input int p);
    int j;
    for (int k = 1; k <= NR; k++) begin
      j = (p + k) % NR;
      if (v[j] && !f[j]) return NR'(1) << j;
    end
    return '0;
  endfunction

  task automatic drive();
    int  k;
    bit  has;
    for (int i = 0; i < NR; i++) begin
      has = en_mask[i] && (sent[i] < cnt[i]);
      k   = has ? sent[i] : ((cnt[i] > 0) ? cnt[i] - 1 : 0);
      req_valid[i] = has || (en_mask[i] && hold[i] && fin[i]);
      req_last[i]  = has ? (sent[i] == cnt[i] - 1) : 1'b1;
      req_data[i*VW +: VW]       = pdata(i, k);
      req_dst_cell[i*CCW +: CCW] = pcell(i, k);
    end
  endtask

  task automatic begin_pass(input int c0, input int c1, input int c2, input int c3,
                            input logic [NR-1:0] h, input logic [NR-1:0] en);
    cnt[0] = c0; cnt[1] = c1; cnt[2] = c2; cnt[3] = c3;
    for (int i = 0; i < NR; i++) sent[i] = 0;
    fin = '0; hold = h; en_mask = en;
    en_rise = -1; en_fall = -1; done_cyc = -1; done_n = 0;
    nvalid = 0; first_v = -1; last_v = -1; m_bcast = 0; m_stall = 0;
    drive();
  endtask

  // One clock: predict the coming edge from the bench model, then observe after it.
  task automatic step();
    logic [NR-1:0] g;
    bit   nxt_v;
    int   gi;
    beat_t b;
    #1;
    g = m_act ? exp_grant(req_valid, fin, m_ptr) : '0;
    chk("req_ready", 128'(req_ready), 128'(g));
    if (m_act && (|(req_valid & ~fin & ~g))) m_stall++;
    nxt_v = (g != '0);
    if (nxt_v) begin
      gi = 0;
      for (int i = 0; i < NR; i++) if (g[i]) gi = i;
      sb.push_back({pdata(gi, sent[gi]), pcell(gi, sent[gi])});
      m_ptr = gi;
      m_bcast++;
      if (req_last[gi]) fin[gi] = 1'b1;
      sent[gi]++;
    end
    if (m_act) fin = fin | req_empty_done;
    if (m_act && (fin == '1)) m_act = 1'b0;

    @(posedge clk);
    @(negedge clk);
    cyc++;
    chk("out_valid", 128'(out_valid), 128'(nxt_v));
    chk("valid_without_enable", 128'(out_valid & ~motion_update_enable), 128'(0));
    if (out_valid) begin
      chk("sb_nonempty", 128'(sb.size() != 0), 128'(1));
      if (sb.size() != 0) begin
        b = sb.pop_front();
        chk("out_data", 128'(out_data), 128'(b.d));
        chk("out_dst_cell", 128'(out_dst_cell), 128'(b.c));
      end
      nvalid++;
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
    end
    if (motion_update_enable && !en_prev) en_rise = cyc;
    if (!motion_update_enable && en_prev) en_fall = cyc;
    en_prev = motion_update_enable;
    if (mu_done) begin
      done_n++;
      done_cyc = cyc;
    end
    mu_start       = 1'b0;
    req_empty_done = '0;
    drive();
  endtask

  task automatic start_pass();
    mu_start = 1'b1;
    sc = cyc;
    step();
    m_act = 1'b1;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while (done_n == 0 && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_done_seen"}, 128'(done_n), 128'(1));
    chk({tag, "_sb_drained"}, 128'(sb.size()), 128'(0));
  endtask

  initial begin
    int n;
    rst = 1'b0; mu_start = 1'b0; req_valid = '0; req_last = '0;
    req_empty_done = '0; req_data = '0; req_dst_cell = '0;
    m_ptr = 0; m_act = 1'b0; en_prev = 1'b0; cyc = 0;
    begin_pass(0, 0, 0, 0, '0, '0);

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_enable", 128'(motion_update_enable), 128'(0));
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_ready", 128'(req_ready), 128'(0));
    rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", 128'(mu_busy), 128'(0));
    chk("idle_done", 128'(mu_done), 128'(0));
    chk("idle_data", 128'(out_data), 128'(0));
    chk("idle_cell", 128'(out_dst_cell), 128'(0));

    // T1: four requesters, two particles each; r0 alone in the first cycle
    begin_pass(2, 2, 2, 2, '0, 4'b0001);
    start_pass();
    step();
    en_mask = '1;
    drive();
    wait_done(40, "t1");
    chk("t1_beats", 128'(nvalid), 128'(8));
    chk("t1_en_rise", 128'(en_rise), 128'(sc + 1));
    chk("t1_en_fall", 128'(en_fall), 128'(last_v + 1));
    chk("t1_done_gap", 128'(done_cyc), 128'(en_fall + GC));
    chk("t1_busy_at_done", 128'(mu_busy), 128'(0));
`ifdef MU_SCHED_STATS_EN
    chk("t1_stat_bcast", 128'(stat_bcast_count), 128'(8));
    chk("t1_stat_stall", 128'(stat_stall_count), 128'(m_stall));
`endif

    // T2: only r2 with five particles, others report empty
    begin_pass(0, 0, 5, 0, '0, 4'b0100);
    start_pass();
    req_empty_done = 4'b1011;
    wait_done(40, "t2");
    chk("t2_beats", 128'(nvalid), 128'(5));
    chk("t2_back_to_back", 128'(last_v - first_v + 1), 128'(5));
`ifdef MU_SCHED_STATS_EN
    chk("t2_stat_bcast", 128'(stat_bcast_count), 128'(5));
    chk("t2_stat_stall", 128'(stat_stall_count), 128'(0));
    step();
    chk("t2_stat_hold", 128'(stat_bcast_count), 128'(5));
`endif

    // T3: r1 keeps req_valid high after its last particle
    begin_pass(2, 1, 2, 2, 4'b0010, '1);
    start_pass();
    wait_done(40, "t3");
    chk("t3_beats", 128'(nvalid), 128'(7));

    // T4: mu_start during ACTIVE and during GUARD is dropped
    begin_pass(2, 2, 2, 2, '0, '1);
    start_pass();
    step();
    mu_start = 1'b1;
    step();
    chk("t4_busy_active", 128'(mu_busy), 128'(1));
    n = 0;
    while (motion_update_enable && n < 40) begin
      step();
      n++;
    end
    mu_start = 1'b1;
    step();
    wait_done(20, "t4");
    for (int i = 0; i < 6; i++) step();
    chk("t4_single_done", 128'(done_n), 128'(1));
    chk("t4_idle_after", 128'(mu_busy), 128'(0));
    chk("t4_beats", 128'(nvalid), 128'(8));

    // T6: every requester empty
    begin_pass(0, 0, 0, 0, '0, '0);
    start_pass();
    req_empty_done = '1;
    wait_done(20, "t6");
    chk("t6_beats", 128'(nvalid), 128'(0));
    chk("t6_en_width", 128'(en_fall - en_rise), 128'(2));
    chk("t6_done_gap", 128'(done_cyc), 128'(en_fall + GC));

    // T5: asynchronous reset mid-pass while a beat is on the bus
    begin_pass(2, 2, 2, 2, '0, '1);
    start_pass();
    step();
    step();
    chk("t5_valid_before", 128'(out_valid), 128'(1));
    #2;
    rst = 1'b0;
    #1;
    chk("t5_async_enable", 128'(motion_update_enable), 128'(0));
    chk("t5_async_valid", 128'(out_valid), 128'(0));
    chk("t5_async_ready", 128'(req_ready), 128'(0));
    chk("t5_async_busy", 128'(mu_busy), 128'(0));
    m_act = 1'b0; m_ptr = 0; sb.delete(); en_prev = 1'b0;
    begin_pass(0, 0, 0, 0, '0, '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_idle_busy", 128'(mu_busy), 128'(0));
    chk("t5_idle_enable", 128'(motion_update_enable), 128'(0));
    begin_pass(2, 2, 2, 2, '0, '1);
    start_pass();
    wait_done(40, "t5");
    chk("t5_beats", 128'(nvalid), 128'(8));
    chk("t5_done_gap", 128'(done_cyc), 128'(en_fall + GC));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
